lsu_align_seq: RTL

- Load/store sequencer between the core's execute stage and the byte-lane data memory.
- Shifts store data and byte enables to the lane selected by addr[1:0], and shifts/extends load data back.
- Splits word-crossing accesses into two word accesses, stalling the core via a ready/valid handshake.
- The data memory has a registered read: mem_rdata is valid the cycle after the address is driven.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_shift.sv | 47 ++++
 rtl/lsu_align_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and access decode helpers for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD0,
    ST_LD1,
    ST_ST1,
    ST_RESP
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned stores are meaningless, so ctrl[2] on a store is rejected.
  function automatic logic is_illegal(input logic we, input logic [2:0] ctrl);
    return (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111) || (we && ctrl[2]);
  endfunction

  function automatic logic is_cross(input logic [1:0] off, input logic [2:0] ctrl);
    logic [3:0] last;
    last = {2'b00, off} + {1'b0, size_bytes(ctrl)};
    return last > 4'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Combinational byte-lane steering: store data/enables into lanes, load data out of lanes with extension.
module lsu_lane_shift
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [3:0]  wren_lo,
  output logic [3:0]  wren_hi,
  output logic [31:0] rdata_ext
);

  logic [2:0]         size;
  logic [7:0]         mask;
  logic [63:0]        wide_w;
  logic [63:0]        wide_r;
  logic [31:0]        sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    size      = size_bytes(ctrl);
    mask      = (size == 3'd1) ? 8'h01 : (size == 3'd2) ? 8'h03 : 8'h0F;
    mask      = mask << off;
    wren_lo   = mask[3:0];
    wren_hi   = mask[7:4];
    // The upper half of the 64-bit shift is exactly wdata >> 8*(4-off).
    wide_w    = {32'h0, wdata} << {off, 3'b000};
    wdata_lo  = wide_w[31:0];
    wdata_hi  = wide_w[63:32];
    wide_r    = {rdata_hi, rdata_lo} >> {off, 3'b000};
    sel       = wide_r[31:0];
    byte_s    = signed'(sel[7:0]);
    half_s    = signed'(sel[15:0]);
    rdata_ext = sel;
    case (size)
      3'd1:    rdata_ext = ctrl[2] ? {24'h0, sel[7:0]}  : 32'(byte_s);
      3'd2:    rdata_ext = ctrl[2] ? {16'h0, sel[15:0]} : 32'(half_s);
      default: rdata_ext = sel;
    endcase
  end

endmodule

// File: rtl/lsu_align_seq.sv
// Load/store sequencer: lane alignment, word-crossing split and registered response.
// LSU_SPLIT_EN builds the two-access split path; without it, crossing accesses fault.
module lsu_align_seq
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [MEM_AW-1:0] mem_word,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wren,
  input  logic [31:0]       mem_rdata
);

  localparam logic [MEM_AW-1:0] WORD_ONE = MEM_AW'(1);

  state_t            state_q, state_d;
  logic              we_q;
  logic [2:0]        ctrl_q;
  logic [1:0]        off_q;
  logic [MEM_AW-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd0_q;
  logic              cross_q;

  logic              accept;
  logic              in_idle;
  logic              req_illegal, req_cross, req_bad;
  logic [MEM_AW-1:0] req_word;
  logic              load_done;

  logic [2:0]        ls_ctrl;
  logic [1:0]        ls_off;
  logic [31:0]       ls_wdata, ls_lo, ls_hi;
  logic [31:0]       ls_wdata_lo, ls_wdata_hi, ls_rdata;
  logic [3:0]        ls_wren_lo, ls_wren_hi;

  assign in_idle     = (state_q == ST_IDLE);
  assign req_ready   = in_idle;
  assign accept      = req_valid & req_ready;
  assign req_word    = req_addr[MEM_AW+1:2];
  assign req_illegal = is_illegal(req_we, req_ctrl);
  assign req_cross   = is_cross(req_addr[1:0], req_ctrl);
`ifdef LSU_SPLIT_EN
  assign req_bad     = req_illegal;
`else
  assign req_bad     = req_illegal | req_cross;
  logic unused_split;
  assign unused_split = ^{ls_wren_hi, ls_wdata_hi, cross_q, we_q};
`endif

  logic unused_addr;
  assign unused_addr = ^req_addr[31:MEM_AW+2];

  // The shifter sees the live request while idle and the captured one afterwards.
  assign ls_ctrl  = in_idle ? req_ctrl      : ctrl_q;
  assign ls_off   = in_idle ? req_addr[1:0] : off_q;
  assign ls_wdata = in_idle ? req_wdata     : wdata_q;
  assign ls_lo    = (state_q == ST_LD1) ? rd0_q     : mem_rdata;
  assign ls_hi    = (state_q == ST_LD1) ? mem_rdata : 32'h0;

  lsu_lane_shift u_lane (
    .ctrl      (ls_ctrl),
    .off       (ls_off),
    .wdata     (ls_wdata),
    .rdata_lo  (ls_lo),
    .rdata_hi  (ls_hi),
    .wdata_lo  (ls_wdata_lo),
    .wdata_hi  (ls_wdata_hi),
    .wren_lo   (ls_wren_lo),
    .wren_hi   (ls_wren_hi),
    .rdata_ext (ls_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad)     state_d = ST_RESP;
          else if (req_we) begin
`ifdef LSU_SPLIT_EN
            state_d = req_cross ? ST_ST1 : ST_RESP;
`else
            state_d = ST_RESP;
`endif
          end
          else             state_d = ST_LD0;
        end
      end
`ifdef LSU_SPLIT_EN
      ST_LD0:  state_d = cross_q ? ST_LD1 : ST_RESP;
      ST_LD1:  state_d = ST_RESP;
      ST_ST1:  state_d = ST_RESP;
`else
      ST_LD0:  state_d = ST_RESP;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory side is combinational; a reset mid-access must not leak a write.
  always_comb begin
    mem_word  = '0;
    mem_wdata = 32'h0;
    mem_wren  = 4'h0;
    case (state_q)
      ST_IDLE: begin
        if (accept && rst_n) begin
          mem_word = req_word;
          if (req_we && !req_bad) begin
            mem_wren  = ls_wren_lo;
            mem_wdata = ls_wdata_lo;
          end
        end
      end
`ifdef LSU_SPLIT_EN
      ST_LD0:  mem_word = cross_q ? word_q + WORD_ONE : word_q;
      ST_LD1:  mem_word = word_q + WORD_ONE;
      ST_ST1: begin
        mem_word  = word_q + WORD_ONE;
        mem_wren  = ls_wren_hi;
        mem_wdata = ls_wdata_hi;
      end
`else
      ST_LD0:  mem_word = word_q;
`endif
      ST_RESP: mem_word = word_q;
      default: mem_word = '0;
    endcase
  end

  // Capture the accepted request and the first read word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      ctrl_q  <= 3'b000;
      off_q   <= 2'b00;
      word_q  <= '0;
      wdata_q <= 32'h0;
      cross_q <= 1'b0;
      rd0_q   <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        ctrl_q  <= req_ctrl;
        off_q   <= req_addr[1:0];
        word_q  <= req_word;
        wdata_q <= req_wdata;
        cross_q <= req_cross & ~req_illegal;
      end
      if (state_q == ST_LD0) rd0_q <= mem_rdata;
    end
  end

  assign load_done = (state_d == ST_RESP) && ((state_q == ST_LD0) || (state_q == ST_LD1));

  // Response stage: registered on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= (state_d == ST_RESP);
      rsp_fault <= accept & req_bad;
      rsp_rdata <= load_done ? ls_rdata : 32'h0;
    end
  end

endmodule
